// File: rtl/hci_mem_rr_arbiter.sv
// Round-robin arbiter sharing one hci_mem target between N_INIT initiators.
// Grant is combinational; the selection is held while the target stalls, and read responses return after RLAT cycles.
module hci_mem_rr_arbiter #(
  parameter int unsigned N_INIT = 4,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned UW     = 1,
  parameter int unsigned RLAT   = 1,
  parameter int unsigned IW     = (N_INIT > 1) ? $clog2(N_INIT) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [N_INIT-1:0]        in_req_i,
  output logic [N_INIT-1:0]        in_gnt_o,
  input  logic [N_INIT*AW-1:0]     in_add_i,
  input  logic [N_INIT-1:0]        in_wen_i,
  input  logic [N_INIT*DW-1:0]     in_data_i,
  input  logic [N_INIT*DW/8-1:0]   in_be_i,
  input  logic [N_INIT*UW-1:0]     in_user_i,
  output logic [N_INIT-1:0]        in_r_valid_o,
  output logic [DW-1:0]            in_r_data_o,
  output logic [UW-1:0]            in_r_user_o,
  output logic                     out_req_o,
  input  logic                     out_gnt_i,
  output logic [AW-1:0]            out_add_o,
  output logic                     out_wen_o,
  output logic [DW-1:0]            out_data_o,
  output logic [DW/8-1:0]          out_be_o,
  output logic [IW-1:0]            out_id_o,
  output logic [UW-1:0]            out_user_o,
  input  logic [DW-1:0]            out_r_data_i,
  input  logic [UW-1:0]            out_r_user_i
);

  localparam int unsigned   BW    = DW / 8;
  localparam int unsigned   IW1   = IW + 1;
  localparam logic [IW:0]   N_EXT = IW1'(N_INIT);
  localparam logic [IW-1:0] LAST  = IW'(N_INIT - 1);

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic [IW-1:0] scan_idx, winner, winner_inc;
  logic [IW:0]   scan_pos;
  logic          scan_found;
  logic          hs;

  logic [RLAT-1:0] pipe_vld_q;
  logic [IW-1:0]   pipe_idx_q [RLAT];

  // Scan ptr, ptr+1, ... with wrap; first requester wins.
  always_comb begin
    scan_idx   = ptr_q;
    scan_pos   = '0;
    scan_found = 1'b0;
    for (int k = 0; k < N_INIT; k++) begin
      scan_pos = {1'b0, ptr_q} + IW1'(k);
      if (scan_pos >= N_EXT) scan_pos = scan_pos - N_EXT;
      if (!scan_found && in_req_i[scan_pos[IW-1:0]]) begin
        scan_idx   = scan_pos[IW-1:0];
        scan_found = 1'b1;
      end
    end
  end

  assign winner     = (state_q == LOCKED) ? lock_idx_q : scan_idx;
  assign winner_inc = (winner == LAST) ? '0 : winner + 1'b1;
  assign out_req_o  = (state_q == LOCKED) ? in_req_i[lock_idx_q] : |in_req_i;
  assign hs         = out_req_o & out_gnt_i;
  assign out_id_o   = winner;

  always_comb begin
    out_add_o  = '0;
    out_wen_o  = 1'b0;
    out_data_o = '0;
    out_be_o   = '0;
    out_user_o = '0;
    in_gnt_o   = '0;
    for (int i = 0; i < N_INIT; i++) begin
      if (winner == IW'(i)) begin
        out_add_o   = in_add_i[i*AW +: AW];
        out_wen_o   = in_wen_i[i];
        out_data_o  = in_data_i[i*DW +: DW];
        out_be_o    = in_be_i[i*BW +: BW];
        out_user_o  = in_user_i[i*UW +: UW];
        in_gnt_o[i] = hs;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      UNLOCKED: begin
        if (hs) begin
          ptr_d = winner_inc;
        end else if (out_req_o) begin
          state_d    = LOCKED;
          lock_idx_d = winner;
        end
      end
      LOCKED: begin
        if (hs) begin
          state_d = UNLOCKED;
          ptr_d   = winner_inc;
        end else if (!out_req_o) begin
          // Initiator withdrew without a grant: release, keep fairness pointer.
          state_d = UNLOCKED;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= UNLOCKED;
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else if (clear_i) begin
      state_q    <= UNLOCKED;
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < RLAT; k++) pipe_idx_q[k] <= '0;
    end else if (clear_i) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < RLAT; k++) pipe_idx_q[k] <= '0;
    end else begin
      for (int k = RLAT - 1; k > 0; k--) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_idx_q[k] <= pipe_idx_q[k-1];
      end
      pipe_vld_q[0] <= hs & out_wen_o;
      pipe_idx_q[0] <= winner;
    end
  end

  always_comb begin
    in_r_valid_o = '0;
    if (pipe_vld_q[RLAT-1]) in_r_valid_o[pipe_idx_q[RLAT-1]] = 1'b1;
  end

  assign in_r_data_o = out_r_data_i;
  assign in_r_user_o = out_r_user_i;

endmodule

// File: tb/tb_hci_mem_rr_arbiter.sv
// Directed bench for hci_mem_rr_arbiter: one RLAT=1 and one RLAT=3 instance on shared stimulus.
module tb_hci_mem_rr_arbiter;
  localparam int N = 4, AW = 32, DW = 32, UW = 1, IW = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni, clear_i;
  logic [N-1:0]      in_req_i, in_wen_i;
  logic [N*AW-1:0]   in_add_i;
  logic [N*DW-1:0]   in_data_i;
  logic [N*DW/8-1:0] in_be_i;
  logic [N*UW-1:0]   in_user_i;
  logic              out_gnt_i;
  logic [DW-1:0]     out_r_data_i;
  logic [UW-1:0]     out_r_user_i;

  logic [N-1:0] gnt1, rv1, gnt3, rv3;
  logic [DW-1:0] rdata1, rdata3, odata1, odata3;
  logic [UW-1:0] ruser1, ruser3, ouser1, ouser3;
  logic req1, req3, wen1, wen3;
  logic [AW-1:0] add1, add3;
  logic [DW/8-1:0] be1, be3;
  logic [IW-1:0] id1, id3;

  int n_chk = 0, n_pass = 0;
  logic [N-1:0] e;

  always #5 clk_i = ~clk_i;

  hci_mem_rr_arbiter #(.N_INIT(N), .AW(AW), .DW(DW), .UW(UW), .RLAT(1)) u1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .in_req_i(in_req_i), .in_gnt_o(gnt1), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
    .in_data_i(in_data_i), .in_be_i(in_be_i), .in_user_i(in_user_i),
    .in_r_valid_o(rv1), .in_r_data_o(rdata1), .in_r_user_o(ruser1),
    .out_req_o(req1), .out_gnt_i(out_gnt_i), .out_add_o(add1), .out_wen_o(wen1),
    .out_data_o(odata1), .out_be_o(be1), .out_id_o(id1), .out_user_o(ouser1),
    .out_r_data_i(out_r_data_i), .out_r_user_i(out_r_user_i));

  hci_mem_rr_arbiter #(.N_INIT(N), .AW(AW), .DW(DW), .UW(UW), .RLAT(3)) u3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .in_req_i(in_req_i), .in_gnt_o(gnt3), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
    .in_data_i(in_data_i), .in_be_i(in_be_i), .in_user_i(in_user_i),
    .in_r_valid_o(rv3), .in_r_data_o(rdata3), .in_r_user_o(ruser3),
    .out_req_o(req3), .out_gnt_i(out_gnt_i), .out_add_o(add3), .out_wen_o(wen3),
    .out_data_o(odata3), .out_be_o(be3), .out_id_o(id3), .out_user_o(ouser3),
    .out_r_data_i(out_r_data_i), .out_r_user_i(out_r_user_i));

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_clear();
    next_cycle();
    in_req_i = '0;
    clear_i  = 1'b1;
    next_cycle();
    clear_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #2;
    n_chk++; if (rv1 !== 4'b0000) $display("FAIL reset_rvalid: got %b exp 0000", rv1); else n_pass++;
    n_chk++; if (req1 !== 1'b0) $display("FAIL reset_req: got %b exp 0", req1); else n_pass++;
    n_chk++; if (gnt1 !== 4'b0000) $display("FAIL reset_gnt: got %b exp 0000", gnt1); else n_pass++;
    n_chk++; if (rv3 !== 4'b0000) $display("FAIL reset_rvalid3: got %b exp 0000", rv3); else n_pass++;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_single_read();
    next_cycle();
    in_req_i = 4'b0100;
    in_add_i[2*AW +: AW] = 32'h10;
    out_gnt_i = 1'b1;
    @(negedge clk_i);
    n_chk++; if (gnt1 !== 4'b0100) $display("FAIL single_gnt: got %b exp 0100", gnt1); else n_pass++;
    n_chk++; if (id1 !== 2'd2) $display("FAIL single_id: got %0d exp 2", id1); else n_pass++;
    n_chk++; if (add1 !== 32'h10) $display("FAIL single_add: got %h exp 00000010", add1); else n_pass++;
    n_chk++; if (rv1 !== 4'b0000) $display("FAIL single_rv_early: got %b exp 0000", rv1); else n_pass++;
    next_cycle();
    in_req_i = '0;
    out_r_data_i = 32'hCAFE_0010;
    out_r_user_i = 1'b1;
    @(negedge clk_i);
    n_chk++; if (rv1 !== 4'b0100) $display("FAIL single_rv: got %b exp 0100", rv1); else n_pass++;
    n_chk++; if (rdata1 !== 32'hCAFE_0010) $display("FAIL single_rdata: got %h exp cafe0010", rdata1); else n_pass++;
    n_chk++; if (ruser1 !== 1'b1) $display("FAIL single_ruser: got %b exp 1", ruser1); else n_pass++;
    out_r_user_i = 1'b0;
  endtask

  task automatic test_rr_all();
    pulse_clear();
    in_req_i = 4'b1111;
    out_gnt_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      e = 4'b0001 << (c % 4);
      n_chk++; if (gnt1 !== e) $display("FAIL rr_gnt c%0d: got %b exp %b", c, gnt1, e); else n_pass++;
      e = (c == 0) ? 4'b0000 : (4'b0001 << ((c - 1) % 4));
      n_chk++; if (rv1 !== e) $display("FAIL rr_rv c%0d: got %b exp %b", c, rv1, e); else n_pass++;
      next_cycle();
    end
    in_req_i = '0;
    @(negedge clk_i);
    n_chk++; if (rv1 !== 4'b1000) $display("FAIL rr_rv_last: got %b exp 1000", rv1); else n_pass++;
  endtask

  task automatic test_lock();
    next_cycle();
    in_req_i = 4'b1010;
    in_add_i[1*AW +: AW] = 32'h100;
    in_add_i[3*AW +: AW] = 32'h300;
    out_gnt_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) in_req_i = 4'b1011;
      @(negedge clk_i);
      n_chk++; if (id1 !== 2'd1) $display("FAIL lock_id c%0d: got %0d exp 1", c, id1); else n_pass++;
      n_chk++; if (add1 !== 32'h100) $display("FAIL lock_add c%0d: got %h exp 00000100", c, add1); else n_pass++;
      n_chk++; if (gnt1 !== 4'b0000) $display("FAIL lock_gnt c%0d: got %b exp 0000", c, gnt1); else n_pass++;
      next_cycle();
    end
    out_gnt_i = 1'b1;
    @(negedge clk_i);
    n_chk++; if (gnt1 !== 4'b0010) $display("FAIL lock_release_gnt: got %b exp 0010", gnt1); else n_pass++;
    next_cycle();
    in_req_i = 4'b1001;
    @(negedge clk_i);
    n_chk++; if (rv1 !== 4'b0010) $display("FAIL lock_rv1: got %b exp 0010", rv1); else n_pass++;
    n_chk++; if (gnt1 !== 4'b1000) $display("FAIL lock_next_gnt: got %b exp 1000", gnt1); else n_pass++;
    n_chk++; if (add1 !== 32'h300) $display("FAIL lock_next_add: got %h exp 00000300", add1); else n_pass++;
    next_cycle();
    in_req_i = '0;
    @(negedge clk_i);
    n_chk++; if (rv1 !== 4'b1000) $display("FAIL lock_rv3: got %b exp 1000", rv1); else n_pass++;
  endtask

  task automatic test_write();
    next_cycle();
    in_req_i = 4'b0001;
    in_wen_i = 4'b1110;
    out_gnt_i = 1'b1;
    @(negedge clk_i);
    n_chk++; if (gnt1 !== 4'b0001) $display("FAIL write_gnt: got %b exp 0001", gnt1); else n_pass++;
    n_chk++; if (wen1 !== 1'b0) $display("FAIL write_wen: got %b exp 0", wen1); else n_pass++;
    next_cycle();
    in_req_i = 4'b0011;
    in_wen_i = 4'b1111;
    @(negedge clk_i);
    n_chk++; if (rv1 !== 4'b0000) $display("FAIL write_rv: got %b exp 0000", rv1); else n_pass++;
    n_chk++; if (gnt1 !== 4'b0010) $display("FAIL write_ptr_gnt: got %b exp 0010", gnt1); else n_pass++;
    next_cycle();
    in_req_i = '0;
    @(negedge clk_i);
    n_chk++; if (rv1 !== 4'b0010) $display("FAIL write_follow_rv: got %b exp 0010", rv1); else n_pass++;
  endtask

  task automatic test_rlat3();
    pulse_clear();
    out_gnt_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_req_i = (c < 3) ? (4'b0001 << c) : 4'b0000;
      @(negedge clk_i);
      e = (c >= 3 && c <= 5) ? (4'b0001 << (c - 3)) : 4'b0000;
      n_chk++; if (rv3 !== e) $display("FAIL rlat3_rv c%0d: got %b exp %b", c, rv3, e); else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_clear_hs();
    in_req_i = 4'b0100;
    out_gnt_i = 1'b1;
    clear_i = 1'b1;
    next_cycle();
    clear_i = 1'b0;
    in_req_i = 4'b1001;
    @(negedge clk_i);
    n_chk++; if (rv1 !== 4'b0000) $display("FAIL clear_rv: got %b exp 0000", rv1); else n_pass++;
    n_chk++; if (gnt1 !== 4'b0001) $display("FAIL clear_ptr_gnt: got %b exp 0001", gnt1); else n_pass++;
    next_cycle();
    in_req_i = 4'b0100;
    @(negedge clk_i);
    n_chk++; if (gnt1 !== 4'b0100) $display("FAIL rst_pre_gnt: got %b exp 0100", gnt1); else n_pass++;
    next_cycle();
    in_req_i = '0;
    #1 rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    n_chk++; if (rv1 !== 4'b0000) $display("FAIL rst_rv: got %b exp 0000", rv1); else n_pass++;
    next_cycle();
    in_req_i = 4'b1001;
    @(negedge clk_i);
    n_chk++; if (gnt1 !== 4'b0001) $display("FAIL rst_ptr_gnt: got %b exp 0001", gnt1); else n_pass++;
    next_cycle();
    in_req_i = '0;
  endtask

  initial begin
    clear_i = 1'b0;
    in_req_i = '0;
    in_wen_i = 4'b1111;
    in_add_i = '0;
    in_data_i = '0;
    in_be_i = '1;
    in_user_i = '0;
    out_gnt_i = 1'b0;
    out_r_data_i = '0;
    out_r_user_i = '0;
    test_reset();
    test_single_read();
    test_rr_all();
    test_lock();
    test_write();
    test_rlat3();
    test_clear_hs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hci_mem_rr_arbiter.md
Name: hci_mem_rr_arbiter

Overview:
- Shares one hci_mem target port (memory bank or downstream TCDM port) between N_INIT initiators with round-robin arbitration.
- Keeps the selected request stable while the target stalls (grant lock).
- Returns responses to the issuing initiator using a fixed-latency response pipeline.
- Sits between accelerator/core-side hci_mem initiators and a single memory-side hci_mem target.

Parameters:
- N_INIT, 4, number of initiators (>=2).
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.
- UW, 1, user-field width.
- RLAT, 1, fixed target read latency in cycles from handshake to r_data (>=1).
- IW, $clog2(N_INIT), width of the index carried on out_id_o.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear of all state.
- in_req_i  in  N_INIT  per-initiator request.
- in_gnt_o  out  N_INIT  per-initiator grant.
- in_add_i  in  N_INIT*AW  per-initiator address.
- in_wen_i  in  N_INIT  per-initiator write-enable (1 = read, 0 = write).
- in_data_i  in  N_INIT*DW  per-initiator write data.
- in_be_i  in  N_INIT*DW/8  per-initiator byte enables.
- in_user_i  in  N_INIT*UW  per-initiator user field.
- in_r_valid_o  out  N_INIT  one-hot response valid.
- in_r_data_o  out  DW  response data, broadcast to all initiators.
- in_r_user_o  out  UW  response user field, broadcast.
- out_req_o  out  1  target request.
- out_gnt_i  in  1  target grant.
- out_add_o  out  AW  selected address.
- out_wen_o  out  1  selected write-enable.
- out_data_o  out  DW  selected write data.
- out_be_o  out  DW/8  selected byte enables.
- out_id_o  out  IW  index of the selected initiator.
- out_user_o  out  UW  selected user field.
- out_r_data_i  in  DW  target response data.
- out_r_user_i  in  UW  target response user field.

Behaviour:
- State: rr pointer ptr (IW bits), lock flag, lock_idx (IW bits), response pipeline of RLAT stages, each stage holding {valid, idx}.
- Reset (rst_ni = 0, asynchronous) and clear_i = 1 (synchronous) both set:
  - ptr = 0, lock = 0;
  - all pipeline valid bits = 0, so in_r_valid_o = 0.
- Selection, when unlocked:
  - winner = first i with in_req_i[i] = 1, scanning ptr, ptr+1, ... and wrapping modulo N_INIT.
  - When locked, winner = lock_idx.
- out_req_o = OR of in_req_i when unlocked; in_req_i[lock_idx] when locked.
- out_add_o/wen/data/be/user are muxed from the winner; out_id_o = winner. Address/data outputs are don't-care when out_req_o = 0.
- in_gnt_o[winner] = out_gnt_i & out_req_o; all other in_gnt_o bits = 0. Combinational, zero added latency.
- Handshake hs = out_req_o & out_gnt_i.
- State machine, two states:
  - UNLOCKED: out_req_o & !out_gnt_i -> LOCKED with lock_idx = winner. hs -> stay UNLOCKED, ptr <= (winner+1) mod N_INIT.
  - LOCKED: hs -> UNLOCKED, ptr <= (lock_idx+1) mod N_INIT. Initiator drops req without grant (protocol violation) -> UNLOCKED, ptr unchanged.
  - No request -> ptr holds.
- Response pipeline:
  - stage0 <= {hs & out_wen_o, winner} each cycle; stage k <= stage k-1.
  - Final stage drives in_r_valid_o[idx] = valid.
  - Read data is therefore seen exactly RLAT cycles after the handshake cycle.
  - Writes produce no r_valid.
- in_r_data_o = out_r_data_i and in_r_user_o = out_r_user_i (pass-through).
- Back-to-back handshakes every cycle are supported; the pipeline accepts one entry per cycle with no stall.
- clear_i together with a handshake: the clear wins. That handshake's response is dropped and ptr = 0.
- Reset mid-operation: pending responses are discarded; the target must also be reset.

Test Plan:
- Single initiator 2 reads addr 0x10, RLAT=1, gnt always 1 -> gnt same cycle; r_valid[2] one cycle later; r_data = target value.
- All 4 requesting continuously, gnt=1 -> grant order 0,1,2,3,0,...; each r_valid one-hot, matching index one cycle after its grant.
- Initiators 1 and 3 request, gnt=0 for 3 cycles then 1 -> out_id_o stays 1 and out_add_o stable while stalled; grant goes to 1; next grant goes to 3 even if 0 then requests.
- Write (wen=0) from initiator 0 -> granted, in_r_valid_o stays 0; ptr advances to 1.
- RLAT=3, reads from 0,1,2 on consecutive cycles -> r_valid[0],[1],[2] on cycles 3,4,5 after the first handshake.
- Handshake in the same cycle as clear_i=1 -> no r_valid afterwards; next arbitration starts from index 0. Same result when rst_ni is pulsed low asynchronously instead.
